mem_arbiter: RTL and testbench

Two-port arbiter that shares the SOC's single data/instruction memory between the instruction-fetch unit (port 0) and the load/store unit (port 1). It accepts one request at a time and drives the memory's request interface (`req_valid`, `we`, `addr`, `data`). It waits for `valid_data` and returns read data or a write acknowledge to the winning requester. A watchdog converts a memory that never answers into an error response, so a stalled memory cannot hang the core.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one request at a time to a shared memory and returns data or a timeout error.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority to port 1.
module mem_arbiter #(
   parameter int MEM_DEPTH  = 64,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rq0_valid,
   input  logic                  rq1_valid,
   input  logic                  rq0_we,
   input  logic                  rq1_we,
   input  logic [ADDR_WIDTH-1:0] rq0_addr,
   input  logic [ADDR_WIDTH-1:0] rq1_addr,
   input  logic [DATA_WIDTH-1:0] rq0_wdata,
   input  logic [DATA_WIDTH-1:0] rq1_wdata,
   output logic                  rq0_ready,
   output logic                  rq1_ready,
   output logic                  rsp0_valid,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_req_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_valid_data,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   state_t                  state_q, state_d;
   logic                    port_q, port_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    grant_valid;
   logic                    grant_port;

`ifdef MEM_ARB_RR_EN
   logic                    last_grant_q, last_grant_d;

   // Under contention the port that did not win last time goes next
   always_comb begin
      grant_valid = rq0_valid | rq1_valid;
      if (rq0_valid && rq1_valid) begin
         grant_port = ~last_grant_q;
      end else begin
         grant_port = rq1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if ((state_q == ST_IDLE) && grant_valid) begin
         last_grant_d = grant_port;
      end
   end
`else
   always_comb begin
      grant_valid = rq0_valid | rq1_valid;
      grant_port  = rq1_valid;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      port_d        = port_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      cnt_d         = cnt_q;
      rq0_ready     = 1'b0;
      rq1_ready     = 1'b0;
      rsp0_valid    = 1'b0;
      rsp1_valid    = 1'b0;
      mem_req_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               rq0_ready = ~grant_port;
               rq1_ready = grant_port;
               port_d    = grant_port;
               we_d      = grant_port ? rq1_we    : rq0_we;
               addr_d    = grant_port ? rq1_addr  : rq0_addr;
               wdata_d   = grant_port ? rq1_wdata : rq0_wdata;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_req_valid = 1'b1;
            cnt_d         = '0;
            state_d       = ST_WAIT;
         end
         ST_WAIT: begin
            // A response arriving on the final watchdog cycle still counts as success
            if (mem_valid_data) begin
               rdata_d = we_q ? '0 : mem_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIM) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            rsp0_valid = ~port_q;
            rsp1_valid = port_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of directed transactions plus hand-written
// contention, timeout/late-response and mid-transaction reset sequences.
module tb_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          rq0_valid, rq1_valid, rq0_we, rq1_we;
   logic [AW-1:0] rq0_addr, rq1_addr;
   logic [DW-1:0] rq0_wdata, rq1_wdata;
   logic          rq0_ready, rq1_ready, rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, mem_req_valid, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_valid_data;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem_model [64];
   int            tests_run = 0;
   int            tests_failed = 0;

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_rsp_cyc;
   } vec_t;

   vec_t vecs [8];

   mem_arbiter #(.MEM_DEPTH(64), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
      .rq0_we(rq0_we), .rq1_we(rq1_we),
      .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
      .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
      .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req_valid(mem_req_valid), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_valid_data(mem_valid_data), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [79:0] all_outs();
      return {3'b000, rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
              mem_req_valid, mem_we, mem_addr, mem_wdata};
   endfunction

   // Drives one request, plays the memory with the vector's latency, checks grant/issue/response timing
   task automatic apply_stimulus(input vec_t v);
      if (v.port) begin
         rq1_valid = 1'b1; rq1_we = v.we; rq1_addr = v.addr; rq1_wdata = v.wdata;
      end else begin
         rq0_valid = 1'b1; rq0_we = v.we; rq0_addr = v.addr; rq0_wdata = v.wdata;
      end
      @(negedge clk);
      check_output("grant", {78'd0, rq1_ready, rq0_ready}, v.port ? 80'd2 : 80'd1);
      tick();
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      @(negedge clk);
      check_output("issue", {41'd0, mem_req_valid, mem_we, mem_addr, mem_wdata},
                   {41'd0, 1'b1, v.we, v.addr, v.wdata});
      for (int c = 2; c <= v.exp_rsp_cyc; c++) begin
         tick();
         mem_valid_data = (v.lat != 0) && (c == v.lat + 1);
         mem_rdata = $urandom;
         if (mem_valid_data) begin
            if (mem_we) begin
               mem_model[mem_addr] = mem_wdata;
               mem_rdata = 32'hBAD0BAD0;
            end else begin
               mem_rdata = mem_model[mem_addr];
            end
         end
         @(negedge clk);
         if (c < v.exp_rsp_cyc) begin
            check_output("no_early_rsp", {78'd0, rsp1_valid, rsp0_valid}, 80'd0);
         end else begin
            check_output("rsp", {45'd0, rsp1_valid, rsp0_valid, rsp_err, rsp_rdata},
                         {45'd0, v.port, ~v.port, v.exp_err, v.exp_rdata});
         end
      end
      tick();
      mem_valid_data = 1'b0;
   endtask

   initial begin
      int   grants [4];
      int   gcyc [4];
      int   exp_order [4];
      int   ng;
      logic mem_pend;
      vec_t tv;

      for (int i = 0; i < 64; i++) mem_model[i] = '0;
      mem_model[5] = 32'hDEADBEEF;

      //            port  we    addr   wdata         lat exp_rdata     err   rsp
      vecs[0] = '{1'b0, 1'b0, 6'd5,  32'h00000000, 1,  32'hDEADBEEF, 1'b0, 3};
      vecs[1] = '{1'b1, 1'b1, 6'd63, 32'h12345678, 1,  32'h00000000, 1'b0, 3};
      vecs[2] = '{1'b1, 1'b0, 6'd63, 32'h0000FFFF, 1,  32'h12345678, 1'b0, 3};
      vecs[3] = '{1'b0, 1'b0, 6'd5,  32'h11111111, 3,  32'hDEADBEEF, 1'b0, 5};
      vecs[4] = '{1'b1, 1'b0, 6'd63, 32'h22222222, 16, 32'h12345678, 1'b0, 18};
      vecs[5] = '{1'b0, 1'b1, 6'd0,  32'hA5A5A5A5, 2,  32'h00000000, 1'b0, 4};
      vecs[6] = '{1'b1, 1'b0, 6'd0,  32'h33333333, 1,  32'hA5A5A5A5, 1'b0, 3};
      vecs[7] = '{1'b0, 1'b0, 6'd1,  32'h44444444, 5,  32'h00000000, 1'b0, 7};

`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{1, 1, 1, 1};
`endif

      reset = 1'b1;
      rq0_valid = 1'b0; rq1_valid = 1'b0; rq0_we = 1'b0; rq1_we = 1'b0;
      rq0_addr = '0; rq1_addr = '0; rq0_wdata = '0; rq1_wdata = '0;
      mem_valid_data = 1'b0; mem_rdata = '0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_output("reset_outs", all_outs(), 80'd0);
      tick();

      // Contention straight after reset: both ports request continuously
      grants = '{-1, -1, -1, -1};
      gcyc = '{0, 0, 0, 0};
      ng = 0;
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd5; rq0_wdata = '0;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 6'd6; rq1_wdata = '0;
      for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
         @(negedge clk);
         if (rq0_ready || rq1_ready) begin
            grants[ng] = rq1_ready ? 1 : 0;
            gcyc[ng] = cyc;
            ng++;
         end
         mem_pend = mem_req_valid;
         tick();
         mem_valid_data = mem_pend;
         mem_rdata = $urandom;
      end
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_pend = mem_req_valid;
         tick();
         mem_valid_data = mem_pend;
      end
      mem_valid_data = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("contention_grant%0d", i), 80'(grants[i]), 80'(exp_order[i]));
      end
      for (int i = 1; i < 4; i++) begin
         check_output($sformatf("contention_gap%0d", i), 80'(gcyc[i] - gcyc[i-1]), 80'd4);
      end

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i]);
      end

      // Timeout with no memory answer, then a late response that must be ignored
      tv = '{1'b0, 1'b0, 6'd7, 32'h55555555, 0, 32'h00000000, 1'b1, 18};
      apply_stimulus(tv);
      tick();
      mem_valid_data = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check_output("late_rsp_ignored", {76'd0, rq1_ready, rq0_ready, rsp1_valid, rsp0_valid}, 80'd0);
      tick();
      mem_valid_data = 1'b0;
      @(negedge clk);
      check_output("late_rsp_after", {78'd0, rsp1_valid, rsp0_valid}, 80'd0);
      tick();

      // Reset while waiting on memory drops the transaction
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd5; rq0_wdata = 32'h77777777;
      tick();
      rq0_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_valid_data = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check_output("midop_reset_outs", all_outs(), 80'd0);
      tick();
      mem_valid_data = 1'b0;
      @(negedge clk);
      check_output("midop_no_rsp", {78'd0, rsp1_valid, rsp0_valid}, 80'd0);
      tick();
      tv = '{1'b0, 1'b0, 6'd5, 32'h88888888, 1, 32'hDEADBEEF, 1'b0, 3};
      apply_stimulus(tv);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
